// File: rtl/kbd_event_queue.sv
// kbd_event_queue: PS/2 key strobe decoder with modifier tracking and a registered event FIFO.
// Optional typematic auto-repeat is built in when KBD_TYPEMATIC_EN is defined.
module kbd_event_queue #(
    parameter int DEPTH     = 8,
    parameter int REP_DELAY = 7000000,
    parameter int REP_RATE  = 933333,
    parameter int MAX_HELD  = 7
) (
    input  logic                   CLK_14M,
    input  logic                   reset,
    input  logic [10:0]            PS2_Key,
    input  logic                   pop,
    input  logic                   clr_ovf,
    output logic                   ev_valid,
    output logic [15:0]            ev_data,
    output logic [$clog2(DEPTH):0] ev_count,
    output logic                   akd,
    output logic                   ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(MAX_HELD + 1);

    typedef enum logic [2:0] {ARM, IDLE, CAPTURE, CLASSIFY, PUSH} state_t;

    state_t         state, state_nx;
    logic           old_stb;
    logic [9:0]     key;
    logic [4:0]     mods, mods_cl;
    logic [HW-1:0]  held;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           press, is_shift, is_ctrl, is_lalt, is_ralt, is_caps, is_mod;
    logic           push_key, push_rep, do_push, do_pop, full, drop;
    logic [15:0]    ev_key, rep_word, wdata;

    assign press    = key[9];
    assign is_shift = key[7:0] == 8'h12 || key[7:0] == 8'h59;
    assign is_ctrl  = key[7:0] == 8'h14;
    assign is_lalt  = key[7:0] == 8'h11 && !key[8];
    assign is_ralt  = key[7:0] == 8'h11 && key[8];
    assign is_caps  = key[7:0] == 8'h58;
    assign is_mod   = is_shift || is_ctrl || is_lalt || is_ralt || is_caps;
    assign mods_cl  = {is_ralt ? press : mods[4], is_lalt ? press : mods[3],
                       (is_caps && press) ? ~mods[2] : mods[2],
                       is_ctrl ? press : mods[1], is_shift ? press : mods[0]};

    assign ev_key   = {~press, 1'b0, mods, key[8:0]};
    assign push_key = state == PUSH;
    assign wdata    = push_key ? ev_key : rep_word;
    assign full     = ev_count == (AW + 1)'(DEPTH);
    assign do_pop   = pop && ev_count != '0;
    assign do_push  = (push_key || push_rep) && (!full || do_pop);
    assign drop     = push_key && full && !do_pop;
    assign ev_valid = ev_count != '0;
    assign ev_data  = mem[rd_ptr];
    assign akd      = held != '0;

    // State register
    always_ff @(posedge CLK_14M or posedge reset) begin
        if (reset) state <= ARM;
        else       state <= state_nx;
    end

    // Next-state: wait for a strobe toggle, capture, classify, push non-modifiers
    always_comb begin
        state_nx = state;
        case (state)
            ARM:      state_nx = IDLE;
            IDLE:     state_nx = (PS2_Key[10] != old_stb) ? CAPTURE : IDLE;
            CAPTURE:  state_nx = CLASSIFY;
            CLASSIFY: state_nx = is_mod ? IDLE : PUSH;
            PUSH:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Key capture, modifier state and held-key counter
    always_ff @(posedge CLK_14M or posedge reset) begin
        if (reset) begin
            old_stb <= 1'b0;
            key     <= '0;
            mods    <= '0;
            held    <= '0;
        end else begin
            if (state == ARM) old_stb <= PS2_Key[10];
            if (state == CAPTURE) begin
                key     <= PS2_Key[9:0];
                old_stb <= PS2_Key[10];
            end
            if (state == CLASSIFY) begin
                mods <= mods_cl;
                if (!is_mod)
                    held <= press ? (held != HW'(MAX_HELD) ? held + HW'(1) : held)
                                  : (held != '0 ? held - HW'(1) : held);
            end
        end
    end

    // Event FIFO with sticky overflow on dropped key events
    always_ff @(posedge CLK_14M or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ev_count <= '0;
            ovf      <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            ev_count <= ev_count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
            ovf      <= drop ? 1'b1 : clr_ovf ? 1'b0 : ovf;
        end
    end

`ifdef KBD_TYPEMATIC_EN
    localparam int TMAX = REP_DELAY > REP_RATE ? REP_DELAY : REP_RATE;
    localparam int TW   = $clog2(TMAX + 1);

    logic          rep_on, rep_pend, rep_fire;
    logic [8:0]    rep_key;
    logic [TW-1:0] rep_timer;

    assign rep_fire = rep_on && rep_timer == '0;
    assign push_rep = (rep_fire || rep_pend) && state != PUSH;
    assign rep_word = {2'b01, mods, rep_key};

    // Typematic timer; a repeat colliding with a key push waits one cycle
    always_ff @(posedge CLK_14M or posedge reset) begin
        if (reset) begin
            rep_on    <= 1'b0;
            rep_pend  <= 1'b0;
            rep_key   <= '0;
            rep_timer <= '0;
        end else begin
            rep_pend <= (rep_fire || rep_pend) && state == PUSH;
            if (state == CLASSIFY && !is_mod && press) begin
                rep_on    <= 1'b1;
                rep_key   <= key[8:0];
                rep_timer <= TW'(REP_DELAY - 1);
            end else if (state == CLASSIFY && !is_mod && key[8:0] == rep_key) begin
                rep_on    <= 1'b0;
                rep_timer <= '0;
            end else if (rep_fire) begin
                rep_timer <= TW'(REP_RATE - 1);
            end else if (rep_on) begin
                rep_timer <= rep_timer - TW'(1);
            end
        end
    end
`else
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{REP_DELAY, REP_RATE};
    assign push_rep       = 1'b0;
    assign rep_word       = '0;
`endif
endmodule

// File: tb/tb_kbd_event_queue.sv
// tb_kbd_event_queue: directed bench for kbd_event_queue (DEPTH=8, REP_DELAY=20, REP_RATE=10).
module tb_kbd_event_queue;
    logic        CLK_14M = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] PS2_Key = '0;
    logic        pop     = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        ev_valid, akd, ovf;
    logic [15:0] ev_data;
    logic [3:0]  ev_count;
    logic        stb = 1'b0;
    int          checks = 0;
    int          failures = 0;

    kbd_event_queue #(.DEPTH(8), .REP_DELAY(20), .REP_RATE(10), .MAX_HELD(7)) dut (
        .CLK_14M(CLK_14M), .reset(reset), .PS2_Key(PS2_Key), .pop(pop), .clr_ovf(clr_ovf),
        .ev_valid(ev_valid), .ev_data(ev_data), .ev_count(ev_count), .akd(akd), .ovf(ovf)
    );

    always #5 CLK_14M = ~CLK_14M;

    task tick(input int n);
        repeat (n) @(posedge CLK_14M);
        #1;
    endtask

    task drive(input logic [9:0] k);
        stb = ~stb;
        PS2_Key = {stb, k};
    endtask

    task key_evt(input logic [9:0] k);
        tick(1);
        drive(k);
        tick(4);
    endtask

    task pop_one;
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
    endtask

    task test_reset;
        tick(3);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ev_valid); end
        checks++; if (ev_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", ev_count); end
        checks++; if (ev_data !== 16'h0000) begin failures++; $display("FAIL rst_data got=%h exp=0000", ev_data); end
        checks++; if (akd !== 1'b0) begin failures++; $display("FAIL rst_akd got=%b exp=0", akd); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
        reset = 1'b0;
        tick(1);
    endtask

    task test_press;
        tick(1);
        drive(10'h21C);
        tick(3);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL lat3_valid got=%b exp=0", ev_valid); end
        tick(1);
        checks++; if (ev_valid !== 1'b1) begin failures++; $display("FAIL lat4_valid got=%b exp=1", ev_valid); end
        checks++; if (ev_data !== 16'h001C) begin failures++; $display("FAIL press_data got=%h exp=001c", ev_data); end
        checks++; if (akd !== 1'b1) begin failures++; $display("FAIL press_akd got=%b exp=1", akd); end
        checks++; if (ev_count !== 4'd1) begin failures++; $display("FAIL press_count got=%0d exp=1", ev_count); end
        pop_one;
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL pop_valid got=%b exp=0", ev_valid); end
        key_evt(10'h01C);
        checks++; if (ev_data !== 16'h801C) begin failures++; $display("FAIL rel_data got=%h exp=801c", ev_data); end
        checks++; if (akd !== 1'b0) begin failures++; $display("FAIL rel_akd got=%b exp=0", akd); end
        pop_one;
        pop_one;
        checks++; if (ev_count !== 4'd0) begin failures++; $display("FAIL empty_pop got=%0d exp=0", ev_count); end
    endtask

    task test_shift;
        key_evt(10'h212);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL shift_nopush got=%b exp=0", ev_valid); end
        checks++; if (akd !== 1'b0) begin failures++; $display("FAIL shift_akd got=%b exp=0", akd); end
        key_evt(10'h21C);
        checks++; if (ev_data !== 16'h021C) begin failures++; $display("FAIL shift_press got=%h exp=021c", ev_data); end
        pop_one;
        key_evt(10'h01C);
        checks++; if (ev_data !== 16'h821C) begin failures++; $display("FAIL shift_rel got=%h exp=821c", ev_data); end
        pop_one;
        key_evt(10'h012);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL shift_relpush got=%b exp=0", ev_valid); end
        checks++; if (akd !== 1'b0) begin failures++; $display("FAIL shift_end_akd got=%b exp=0", akd); end
    endtask

    task test_caps;
        key_evt(10'h258);
        key_evt(10'h058);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL caps_nopush got=%b exp=0", ev_valid); end
        key_evt(10'h21C);
        checks++; if (ev_data !== 16'h081C) begin failures++; $display("FAIL caps_on got=%h exp=081c", ev_data); end
        pop_one;
        key_evt(10'h01C);
        checks++; if (ev_data !== 16'h881C) begin failures++; $display("FAIL caps_on_rel got=%h exp=881c", ev_data); end
        pop_one;
        key_evt(10'h258);
        key_evt(10'h058);
        key_evt(10'h21C);
        checks++; if (ev_data !== 16'h001C) begin failures++; $display("FAIL caps_off got=%h exp=001c", ev_data); end
        pop_one;
        key_evt(10'h01C);
        pop_one;
    endtask

    task test_ext;
        key_evt(10'h311);
        key_evt(10'h375);
        checks++; if (ev_data !== 16'h2175) begin failures++; $display("FAIL ralt_ext got=%h exp=2175", ev_data); end
        pop_one;
        key_evt(10'h111);
        key_evt(10'h175);
        checks++; if (ev_data !== 16'h8175) begin failures++; $display("FAIL ext_rel got=%h exp=8175", ev_data); end
        pop_one;
        checks++; if (akd !== 1'b0) begin failures++; $display("FAIL ext_akd got=%b exp=0", akd); end
    endtask

    task test_back_to_back;
        key_evt(10'h21C);
        tick(1);
        drive(10'h01C);
        tick(3);
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        checks++; if (ev_count !== 4'd1) begin failures++; $display("FAIL pushpop_count got=%0d exp=1", ev_count); end
        checks++; if (ev_data !== 16'h801C) begin failures++; $display("FAIL pushpop_data got=%h exp=801c", ev_data); end
        pop_one;
    endtask

    task test_late_strobe;
        tick(1);
        drive(10'h21C);
        tick(2);
        drive(10'h01C);
        tick(5);
        checks++; if (ev_count !== 4'd1) begin failures++; $display("FAIL late_first got=%0d exp=1", ev_count); end
        tick(1);
        checks++; if (ev_count !== 4'd2) begin failures++; $display("FAIL late_second got=%0d exp=2", ev_count); end
        checks++; if (ev_data !== 16'h001C) begin failures++; $display("FAIL late_head got=%h exp=001c", ev_data); end
        pop_one;
        checks++; if (ev_data !== 16'h801C) begin failures++; $display("FAIL late_tail got=%h exp=801c", ev_data); end
        pop_one;
    endtask

    task test_repeat;
        tick(1);
        drive(10'h21C);
        tick(4);
        pop_one;
`ifdef KBD_TYPEMATIC_EN
        tick(17);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL rep_early got=%b exp=0", ev_valid); end
        tick(1);
        checks++; if (ev_data !== 16'h401C || ev_valid !== 1'b1) begin failures++; $display("FAIL rep_first got=%h exp=401c", ev_data); end
        pop_one;
        tick(9);
        checks++; if (ev_data !== 16'h401C || ev_valid !== 1'b1) begin failures++; $display("FAIL rep_second got=%h exp=401c", ev_data); end
        pop_one;
        tick(1);
        drive(10'h01C);
        tick(4);
        checks++; if (ev_data !== 16'h801C) begin failures++; $display("FAIL rep_rel got=%h exp=801c", ev_data); end
        pop_one;
        tick(20);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL rep_after_rel got=%b exp=0", ev_valid); end
`else
        tick(30);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL norep got=%b exp=0", ev_valid); end
        key_evt(10'h01C);
        checks++; if (ev_data !== 16'h801C) begin failures++; $display("FAIL norep_rel got=%h exp=801c", ev_data); end
        pop_one;
`endif
    endtask

    task test_overflow;
        logic [7:0] c;
        for (int i = 0; i < 9; i++) begin
            c = 8'h20 + 8'(i);
            key_evt({2'b10, c});
            if (i == 7) begin
                checks++; if (ev_count !== 4'd8 || ovf !== 1'b0) begin failures++; $display("FAIL fill8 got=%0d/%b exp=8/0", ev_count, ovf); end
            end
        end
        checks++; if (ev_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", ev_count); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        checks++; if (ev_data !== 16'h0020) begin failures++; $display("FAIL ovf_head got=%h exp=0020", ev_data); end
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
        pop_one;
        checks++; if (ev_data !== 16'h0021 || ev_count !== 4'd7) begin failures++; $display("FAIL ovf_next got=%h/%0d exp=0021/7", ev_data, ev_count); end
        repeat (4) pop_one;
    endtask

    task test_reset_mid;
        checks++; if (ev_count !== 4'd3 || akd !== 1'b1) begin failures++; $display("FAIL pre_rst got=%0d/%b exp=3/1", ev_count, akd); end
        reset = 1'b1;
        stb = 1'b1;
        PS2_Key = {1'b1, 10'h000};
        tick(1);
        checks++; if (ev_valid !== 1'b0 || ev_count !== 4'd0) begin failures++; $display("FAIL mid_rst_q got=%b/%0d exp=0/0", ev_valid, ev_count); end
        checks++; if (akd !== 1'b0 || ev_data !== 16'h0000) begin failures++; $display("FAIL mid_rst_st got=%b/%h exp=0/0000", akd, ev_data); end
        reset = 1'b0;
        tick(10);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL post_rst_spurious got=%b exp=0", ev_valid); end
        key_evt(10'h21C);
        checks++; if (ev_data !== 16'h001C || akd !== 1'b1) begin failures++; $display("FAIL post_rst_key got=%h/%b exp=001c/1", ev_data, akd); end
        pop_one;
        key_evt(10'h01C);
        pop_one;
    endtask

    initial begin
        test_reset;
        test_press;
        test_shift;
        test_caps;
        test_ext;
        test_back_to_back;
        test_late_strobe;
        test_repeat;
        test_overflow;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
